// File: rtl/layer_sequencer_if.sv
// Bundle of control/status signals between a frame controller (master)
// and the layer sequencer (slave). Clock and reset are separate ports.
//
// Handshake: a stage is launched by a one-cycle stage_en pulse (at most
// one bit set) and is finished when the matching stage_done bit is high
// while the sequencer is waiting for that stage; other done bits and done
// pulses outside the wait phase are ignored. start is a level sampled only
// while idle; abort cancels a run on the next clock edge.
interface layer_sequencer_if #(
    parameter int NUM_STAGES = 6,
    parameter int IDX_W      = 3
);
    logic                  start;
    logic                  abort;
    logic [NUM_STAGES-1:0] stage_mask;
    logic [NUM_STAGES-1:0] stage_done;
    logic [NUM_STAGES-1:0] stage_en;
    logic [NUM_STAGES-1:0] stage_active;
    logic [IDX_W-1:0]      cur_stage;
    logic                  busy;
    logic                  frame_done;
    logic                  err;
    logic [2:0]            dbg_state;

    modport master (
        output start, abort, stage_mask, stage_done,
        input  stage_en, stage_active, cur_stage, busy, frame_done, err, dbg_state
    );

    modport slave (
        input  start, abort, stage_mask, stage_done,
        output stage_en, stage_active, cur_stage, busy, frame_done, err, dbg_state
    );
endinterface

// File: rtl/layer_sequencer.sv
// Layer sequencer: walks the enabled stages of a frame in index order,
// launching each with a one-cycle pulse and waiting for its done pulse.
// Optional per-stage watchdog enabled with macro LAYER_SEQ_TIMEOUT_EN;
// without it err is tied low and a stage may wait indefinitely.
// The FSM state is exported on sif.dbg_state.
module layer_sequencer #(
    parameter int NUM_STAGES     = 6,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int IDX_W          = 3
) (
    input  logic           clk,
    input  logic           rst,
    layer_sequencer_if.slave sif
);

    // Elaboration-time parameter sanity checks.
    if (NUM_STAGES < 2 || NUM_STAGES > 16) begin : g_bad_stages
        $error("layer_sequencer: NUM_STAGES out of range 2..16");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("layer_sequencer: TIMEOUT_CYCLES out of range 1..65535");
    end
    if (IDX_W != $clog2(NUM_STAGES)) begin : g_bad_idx
        $error("layer_sequencer: IDX_W must equal clog2(NUM_STAGES)");
    end

`ifdef LAYER_SEQ_TIMEOUT_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        FINISH = 3'd3,
        ERROR  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        FINISH = 3'd3
    } state_t;
`endif

    state_t                state_q, state_d;
    logic [NUM_STAGES-1:0] mask_q, mask_d;
    logic [IDX_W-1:0]      cur_stage_q, cur_stage_d;

`ifdef LAYER_SEQ_TIMEOUT_EN
    logic                  err_q, err_d;
    logic [15:0]           wdog_q, wdog_d;
`endif

    logic                  first_any;
    logic [IDX_W-1:0]      first_idx;
    logic                  next_any;
    logic [IDX_W-1:0]      next_idx;
    logic [NUM_STAGES-1:0] stage_en_c;
    logic [NUM_STAGES-1:0] stage_active_c;

    // Lowest set bit of the incoming mask: first stage of a new frame.
    always_comb begin
        first_any = 1'b0;
        first_idx = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (sif.stage_mask[i]) begin
                first_any = 1'b1;
                first_idx = IDX_W'(i);
            end
        end
    end

    // Lowest captured-mask bit above the current stage: the next stage to run.
    always_comb begin
        next_any = 1'b0;
        next_idx = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(cur_stage_q))) begin
                next_any = 1'b1;
                next_idx = IDX_W'(i);
            end
        end
    end

    // Next-state logic: sequencing, watchdog and abort override.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        cur_stage_d = cur_stage_q;
`ifdef LAYER_SEQ_TIMEOUT_EN
        err_d       = err_q;
        wdog_d      = wdog_q;
`endif
        case (state_q)
            IDLE: begin
                if (sif.start) begin
                    mask_d = sif.stage_mask;
`ifdef LAYER_SEQ_TIMEOUT_EN
                    err_d  = 1'b0;
`endif
                    if (first_any) begin
                        cur_stage_d = first_idx;
                        state_d     = LAUNCH;
                    end else begin
                        state_d     = FINISH;
                    end
                end
            end
            LAUNCH: begin
                state_d = WAIT;
`ifdef LAYER_SEQ_TIMEOUT_EN
                wdog_d  = '0;
`endif
            end
            WAIT: begin
                if (sif.stage_done[cur_stage_q]) begin
                    if (next_any) begin
                        cur_stage_d = next_idx;
                        state_d     = LAUNCH;
                    end else begin
                        state_d     = FINISH;
                    end
                end
`ifdef LAYER_SEQ_TIMEOUT_EN
                else if (wdog_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ERROR;
                    err_d   = 1'b1;
                end else begin
                    wdog_d  = wdog_q + 16'd1;
                end
`endif
            end
            FINISH: begin
                state_d = IDLE;
            end
`ifdef LAYER_SEQ_TIMEOUT_EN
            ERROR: begin
                state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over any completion seen in the same cycle and leaves
        // the stage index and error flag as they were.
        if (state_q != IDLE && sif.abort) begin
            state_d     = IDLE;
            cur_stage_d = cur_stage_q;
`ifdef LAYER_SEQ_TIMEOUT_EN
            err_d       = err_q;
`endif
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            cur_stage_q <= '0;
`ifdef LAYER_SEQ_TIMEOUT_EN
            err_q       <= 1'b0;
            wdog_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            cur_stage_q <= cur_stage_d;
`ifdef LAYER_SEQ_TIMEOUT_EN
            err_q       <= err_d;
            wdog_q      <= wdog_d;
`endif
        end
    end

    // Output decode from the registered state; all outputs clear with reset.
    always_comb begin
        stage_en_c     = '0;
        stage_active_c = '0;
        if (state_q == LAUNCH) begin
            stage_en_c[cur_stage_q] = 1'b1;
        end
        if (state_q == LAUNCH || state_q == WAIT) begin
            stage_active_c[cur_stage_q] = 1'b1;
        end
    end

    assign sif.stage_en     = stage_en_c;
    assign sif.stage_active = stage_active_c;
    assign sif.cur_stage    = cur_stage_q;
    assign sif.busy         = (state_q != IDLE);
    assign sif.frame_done   = (state_q == FINISH);
    assign sif.dbg_state    = state_q;
`ifdef LAYER_SEQ_TIMEOUT_EN
    assign sif.err          = err_q;
`else
    assign sif.err          = 1'b0;
`endif

endmodule
